// File: rtl/switches_scan_ctrl_if.sv
// Avalon-MM slave bus of the switch scanner: register access plus the
// level interrupt to the Nios II.
interface switches_scan_ctrl_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;

    modport master (output address, chipselect, write_n, writedata,
                    input  readdata, irq);
    modport slave  (input  address, chipselect, write_n, writedata,
                    output readdata, irq);
endinterface

// File: rtl/switches_scan_ctrl.sv
// Slide-switch scanner: 2-FF sync, tick-paced per-bit debounce, edge capture, maskable irq.
// Macro SWITCHES_SCAN_CTRL_DEBOUNCE_EN builds the debouncer; without it STATE follows sync every cycle.
module switches_scan_ctrl #(
    parameter int WIDTH      = 10,
    parameter int TICK_DIV   = 50000,
    parameter int DB_SAMPLES = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [WIDTH-1:0]     in_port,
    switches_scan_ctrl_if.slave  bus
);
    localparam logic [1:0] ADDR_STATE = 2'd0;
    localparam logic [1:0] ADDR_MASK  = 2'd1;
    localparam logic [1:0] ADDR_EDGE  = 2'd2;

    logic [WIDTH-1:0] sync1_q, sync2_q, state_q, edge_q, mask_q;
    logic [2:0]       ctrl_q;
    logic [WIDTH-1:0] state_nxt, edge_set, edge_clr;
    logic [31:0]      rd_nxt;
    logic             wr_en;
    logic             unused_wdata;

    // Bus handshake: a write is accepted on every clk edge with chipselect=1
    // and write_n=0 (no waitrequest, never stalls). Reads carry no strobe:
    // readdata always reflects the address presented one edge earlier.
    assign wr_en        = bus.chipselect && !bus.write_n;
    assign unused_wdata = ^bus.writedata;

`ifdef SWITCHES_SCAN_CTRL_DEBOUNCE_EN
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam int DW = $clog2(DB_SAMPLES) + 1;
    localparam logic [DW-1:0] DB_LAST = DW'(DB_SAMPLES - 1);

    logic [TW-1:0] tick_cnt_q;
    logic [DW-1:0] db_cnt_q [WIDTH];
    logic          tick;

    assign tick = ctrl_q[0] && (tick_cnt_q == TICK_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tick_cnt_q <= '0;
        end else if (!ctrl_q[0] || tick) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_q + 1'b1;
        end
    end

    // A counter is cleared both when the input agrees and when it accepts a change.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < WIDTH; i++) db_cnt_q[i] <= '0;
        end else if (tick) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (sync2_q[i] == state_q[i] || db_cnt_q[i] == DB_LAST)
                    db_cnt_q[i] <= '0;
                else
                    db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state_q;
        for (int i = 0; i < WIDTH; i++) begin
            if (tick && sync2_q[i] != state_q[i] && db_cnt_q[i] == DB_LAST)
                state_nxt[i] = ~state_q[i];
        end
    end
`else
    assign state_nxt = sync2_q;
`endif

    assign edge_set = (state_nxt & ~state_q & {WIDTH{ctrl_q[1]}})
                    | (state_q & ~state_nxt & {WIDTH{ctrl_q[2]}});
    assign edge_clr = (wr_en && bus.address == ADDR_EDGE) ? bus.writedata[WIDTH-1:0] : '0;

    always_comb begin
        rd_nxt = '0;
        case (bus.address)
            ADDR_STATE: rd_nxt[WIDTH-1:0] = state_q;
            ADDR_MASK:  rd_nxt[WIDTH-1:0] = mask_q;
            ADDR_EDGE:  rd_nxt[WIDTH-1:0] = edge_q;
            default:    rd_nxt[2:0]       = ctrl_q;
        endcase
    end

    // Set beats a simultaneous W1C clear of the same EDGE bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            state_q      <= '0;
            edge_q       <= '0;
            mask_q       <= '0;
            ctrl_q       <= 3'b011;
            bus.readdata <= '0;
            bus.irq      <= 1'b0;
        end else begin
            sync1_q      <= in_port;
            sync2_q      <= sync1_q;
            state_q      <= state_nxt;
            edge_q       <= (edge_q & ~edge_clr) | edge_set;
            bus.readdata <= rd_nxt;
            bus.irq      <= |(edge_q & mask_q);
            if (wr_en && bus.address == ADDR_MASK) mask_q <= bus.writedata[WIDTH-1:0];
            if (wr_en && bus.address == 2'd3)      ctrl_q <= bus.writedata[2:0];
        end
    end
endmodule

// File: tb/tb_switches_scan_ctrl.sv
// Bench for switches_scan_ctrl: register vector table, hand-written corner
// sequences, then random traffic checked every cycle against a reference model.
module tb_switches_scan_ctrl;
  localparam int W   = 10;
  localparam int TD  = 4;
  localparam int DBS = 3;
`ifdef SWITCHES_SCAN_CTRL_DEBOUNCE_EN
  localparam bit DB_EN = 1'b1;
`else
  localparam bit DB_EN = 1'b0;
`endif

  logic         clk;
  logic         reset_n;
  logic [W-1:0] in_port;
  switches_scan_ctrl_if bus();

  switches_scan_ctrl #(.WIDTH(W), .TICK_DIV(TD), .DB_SAMPLES(DBS)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .in_port(in_port),
    .bus    (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "time limit");
  end

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // STATE bit flips once DBS consecutive sample ticks have seen the synchronised
  // input differ from it; ticks fall on every TD-th cycle of an enabled run.
  logic [W-1:0] m_sync1, m_sync2, m_state, m_edge, m_mask;
  logic [2:0]   m_ctrl;
  logic [31:0]  m_rd;
  logic         m_irq;
  int           m_phase;
  int           m_runlen [W];

  task automatic model_reset();
    m_sync1 = '0; m_sync2 = '0; m_state = '0; m_edge = '0; m_mask = '0;
    m_ctrl = 3'b011; m_rd = '0; m_irq = 1'b0; m_phase = 0;
    for (int i = 0; i < W; i++) m_runlen[i] = 0;
  endtask

  task automatic model_step();
    logic [31:0]  rd_new;
    logic [W-1:0] st_new, set_bits, clr;
    bit           wr, tick;
    wr = bus.chipselect && !bus.write_n;
    rd_new = '0;
    case (bus.address)
      2'd0: rd_new[W-1:0] = m_state;
      2'd1: rd_new[W-1:0] = m_mask;
      2'd2: rd_new[W-1:0] = m_edge;
      default: rd_new[2:0] = m_ctrl;
    endcase
    st_new = m_state;
    if (DB_EN) begin
      tick = m_ctrl[0] && (m_phase % TD == TD - 1);
      m_phase = m_ctrl[0] ? m_phase + 1 : 0;
      if (tick) begin
        for (int i = 0; i < W; i++) begin
          if (m_sync2[i] != m_state[i]) begin
            m_runlen[i]++;
            if (m_runlen[i] == DBS) begin
              st_new[i] = ~m_state[i];
              m_runlen[i] = 0;
            end
          end else begin
            m_runlen[i] = 0;
          end
        end
      end
    end else begin
      st_new = m_sync2;
    end
    set_bits = '0;
    for (int i = 0; i < W; i++) begin
      if (!m_state[i] && st_new[i] && m_ctrl[1]) set_bits[i] = 1'b1;
      if (m_state[i] && !st_new[i] && m_ctrl[2]) set_bits[i] = 1'b1;
    end
    clr = (wr && bus.address == 2'd2) ? bus.writedata[W-1:0] : '0;
    m_irq   = |(m_edge & m_mask);
    m_edge  = (m_edge & ~clr) | set_bits;
    if (wr && bus.address == 2'd1) m_mask = bus.writedata[W-1:0];
    if (wr && bus.address == 2'd3) m_ctrl = bus.writedata[2:0];
    m_state = st_new;
    m_sync2 = m_sync1;
    m_sync1 = in_port;
    m_rd    = rd_new;
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle();
    @(posedge clk);
    if (!reset_n) model_reset(); else model_step();
    #1;
    if (reset_n) begin
      chk("rd_vs_model", bus.readdata, m_rd);
      chk("irq_vs_model", 32'(bus.irq), 32'(m_irq));
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    bus.address = a; bus.writedata = d; bus.chipselect = 1'b1; bus.write_n = 1'b0;
    cycle();
    bus.chipselect = 1'b0; bus.write_n = 1'b1;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    bus.address = a;
    cycle();
    d = bus.readdata;
  endtask

  task automatic poll(input string name, input logic [1:0] a, input logic [31:0] exp, input int max_lat);
    int lat = 0;
    bit hit = 1'b0;
    bus.address = a;
    for (int i = 1; i <= 40 && !hit; i++) begin
      cycle();
      if (bus.readdata == exp) begin hit = 1'b1; lat = i; end
    end
    chk(name, bus.readdata, exp);
    chk({name, "_in_time"}, 32'(hit && lat <= max_lat), 32'd1);
  endtask

  // ---------------- test ----------------
  typedef struct {
    bit          we;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t        vecs [11];
  logic [31:0] rd;
  int          lat_max;

  initial begin
    vecs[0]  = '{1'b0, 2'd0, 32'h0,        32'h000};
    vecs[1]  = '{1'b0, 2'd1, 32'h0,        32'h000};
    vecs[2]  = '{1'b0, 2'd2, 32'h0,        32'h000};
    vecs[3]  = '{1'b0, 2'd3, 32'h0,        32'h003};
    vecs[4]  = '{1'b1, 2'd1, 32'h0000_02A5, 32'h2A5};
    vecs[5]  = '{1'b1, 2'd1, 32'hFFFF_FFFF, 32'h3FF};
    vecs[6]  = '{1'b1, 2'd0, 32'h0000_0155, 32'h000};
    vecs[7]  = '{1'b1, 2'd3, 32'hFFFF_FFF8, 32'h000};
    vecs[8]  = '{1'b1, 2'd3, 32'hFFFF_FFFF, 32'h007};
    vecs[9]  = '{1'b1, 2'd2, 32'hFFFF_FFFF, 32'h000};
    vecs[10] = '{1'b1, 2'd1, 32'h0,        32'h000};
    lat_max = DB_EN ? 2 + DBS * TD + 1 : 4;

    reset_n = 1'b0; in_port = '0;
    bus.address = '0; bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = '0;
    model_reset();
    repeat (3) cycle();
    reset_n = 1'b1;
    chk("reset_readdata", bus.readdata, 32'h0);
    chk("reset_irq", 32'(bus.irq), 32'h0);

    // register access table
    for (int i = 0; i < 11; i++) begin
      if (vecs[i].we) bus_write(vecs[i].addr, vecs[i].wdata);
      bus_read(vecs[i].addr, rd);
      chk($sformatf("vec%0d_addr%0d", i, vecs[i].addr), rd, vecs[i].exp);
    end
    bus_write(2'd3, 32'h3);

    // bit 0 rises and is debounced; MASK=0 so irq stays low
    in_port = 10'h001;
    poll("rise_state", 2'd0, 32'h001, lat_max);
    bus_read(2'd2, rd);
    chk("rise_edge", rd, 32'h001);
    chk("rise_irq_masked", 32'(bus.irq), 32'h0);

    // unmask -> irq next cycle; W1C -> irq drops next cycle
    bus_write(2'd1, 32'h001);
    chk("irq_same_cycle_as_mask", 32'(bus.irq), 32'h0);
    cycle();
    chk("irq_after_mask", 32'(bus.irq), 32'h1);
    bus_write(2'd2, 32'h001);
    cycle();
    chk("irq_after_clear", 32'(bus.irq), 32'h0);
    bus_read(2'd2, rd);
    chk("edge_after_clear", rd, 32'h000);

    // one-tick glitch on bit 3
    in_port = 10'h009;
    repeat (4) cycle();
    in_port = 10'h001;
    repeat (20) cycle();
    bus_read(2'd0, rd);
    chk("glitch_state", rd, 32'h001);
    bus_read(2'd2, rd);
    chk("glitch_edge", rd, DB_EN ? 32'h000 : 32'h008);
    bus_write(2'd2, 32'h3FF);

    // RUN=0 freezes debounce; then falling-only capture
    bus_write(2'd3, 32'h4);
    in_port = 10'h3FF;
    repeat (50) cycle();
    bus_read(2'd0, rd);
    chk("run0_state", rd, DB_EN ? 32'h001 : 32'h3FF);
    bus_write(2'd3, 32'h5);
    poll("run1_state", 2'd0, 32'h3FF, lat_max);
    bus_read(2'd2, rd);
    chk("rise_disabled_edge", rd, 32'h000);
    in_port = 10'h000;
    poll("fall_state", 2'd0, 32'h000, lat_max);
    bus_read(2'd2, rd);
    chk("fall_edge", rd, 32'h3FF);
    cycle();
    chk("irq_before_reset", 32'(bus.irq), 32'h1);

    // asynchronous reset in the middle of a debounce run
    in_port = 10'h3FF;
    for (int i = 0; i < 40 && !(DB_EN ? m_runlen[0] == 2 : i >= 3); i++) cycle();
    reset_n = 1'b0;
    #1;
    chk("async_rst_readdata", bus.readdata, 32'h0);
    chk("async_rst_irq", 32'(bus.irq), 32'h0);
    model_reset();
    repeat (2) cycle();
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus_read(vecs[i].addr, rd);
      chk($sformatf("post_rst_addr%0d", i), rd, vecs[i].exp);
    end

    // random traffic against the model
    for (int s = 0; s < 150; s++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r <= 5) begin
        if ($urandom_range(0, 1) == 0) in_port = W'($urandom_range(0, (1 << W) - 1));
        else in_port = in_port ^ W'(1 << $urandom_range(0, W - 1));
        repeat ($urandom_range(1, 16)) begin
          bus.address = 2'($urandom_range(0, 3));
          cycle();
        end
      end else if (r == 6) begin
        bus_write(2'd1, $urandom());
      end else if (r == 7) begin
        bus_write(2'd2, $urandom());
      end else if (r == 8) begin
        bus_write(2'd3, {$urandom_range(0, 3) << 1} | 32'($urandom_range(0, 3) != 0));
      end else begin
        bus_write(2'd0, $urandom());
      end
    end
    repeat (20) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
